icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Instruction-supply end of the fetch handshake. Answers the fetch unit's ask_for/out_PC requests with give_you/give_you_ins.
- Built as a direct-mapped cache of 32-bit fetch windows, keyed by halfword-aligned PC, so RVC and straddling instructions need no special handling.
- On a miss it gets the byte-wide memory bus from the memory arbiter, reads 4 bytes, fills the entry, then responds.
- Sits between insfetch and the memory arbiter.

Parameters:
IDX_BITS, 6, index width; entry count = 2^IDX_BITS; index = pc[IDX_BITS:1], tag = pc[31:IDX_BITS+1]

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global ready; when low, all state holds
ask_for  in  1  fetch request valid (from insfetch)
in_PC  in  32  request address, bit 0 always 0
give_you  out  1  one-cycle response valid
give_you_ins  out  32  bytes [pc+3:pc], little-endian
flush  in  1  rob_clear; abort outstanding work
mem_req  out  1  bus request to arbiter
mem_gnt  in  1  arbiter grant, held while mem_req high
mem_a  out  32  byte address on bus
mem_byte  in  8  read data, valid 1 cycle after address
mem_done  out  1  one-cycle pulse releasing the bus

Behaviour:
- Reset (async): state=IDLE; all valid bits 0; give_you=0; give_you_ins=0; mem_req=0; mem_a=0; mem_done=0; byte counter=0. Tag/data arrays are not reset.
- States: IDLE, RESP, WAITG, READ, FILL. Nothing changes while rdy_in=0 (reset excepted).
- IDLE:
  - ask_for && !flush && hit (valid[idx] && tag match) -> latch data into give_you_ins; next cycle give_you=1 (1-cycle hit latency); go RESP.
  - ask_for && !flush && miss -> latch req_pc; mem_req=1; go WAITG.
- RESP:
  - give_you=1 for exactly this cycle; ask_for is ignored in this cycle, because the fetcher's PC updates at this edge.
  - Return to IDLE. Hit throughput is 1 per 2 cycles.
  - If flush is high in this cycle, give_you is still asserted; insfetch discards it.
- WAITG:
  - Hold mem_req=1 until mem_gnt=1.
  - On grant: mem_a=req_pc, cnt=0; go READ.
- READ:
  - Each cycle: mem_a=req_pc+cnt+1, capture mem_byte into buf[8*cnt +: 8] (data for the previous address).
  - After capturing cnt=3: mem_req=0, mem_done=1 for one cycle; go FILL.
  - Address arithmetic is 32-bit, wrapping modulo 2^32.
- FILL:
  - Write tag/data/valid for req_pc.
  - give_you_ins=buf; give_you=1 next cycle (go RESP).
  - Miss latency from the grant edge is 6 cycles to give_you.
- Flush in WAITG: drop mem_req; go IDLE; no fill.
- Flush in READ: finish the byte in flight, then mem_done=1 and mem_req=0 on the next cycle; no fill, no response; go IDLE.
- Flush in FILL: fill still happens (the data is correct); response is suppressed; go IDLE.
- Flush and ask_for in the same IDLE cycle: the request is ignored.
- Index conflict: a new fill overwrites the old entry (direct-mapped).
- Instruction memory is read-only; no invalidation except reset.
- Reset mid-miss: bus released immediately (mem_req=0); no mem_done pulse.

Test Plan:
- Cold miss: reset; ask_for, in_PC=0x0; memory bytes 13 05 f0 0f; grant 2 cycles later -> 4 reads at 0x0..0x3, mem_done pulse, give_you=1 with 0x0ff00513 6 cycles after grant.
- Hit: after the fill above, ask_for in_PC=0x0 -> give_you=1 with 0x0ff00513 on the next cycle, mem_req stays 0; ask_for held through RESP -> no second give_you in that cycle.
- RVC straddle: in_PC=0x2, memory 0x2..0x5 = 01 45 b7 02 -> give_you_ins=0x02b74501; a later request at 0x0 is a miss (different entry).
- Conflict: fill 0x4, then request 0x4+2^(IDX_BITS+1)=0x84 -> miss and refill; 0x4 then misses again.
- Flush mid-READ after 2 bytes -> exactly one more byte cycle, mem_done pulse, no give_you; re-request of the same PC misses.
- Async reset asserted during WAITG between clock edges -> mem_req drops immediately; all valid bits cleared; previously hit PC now misses.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-bus signals of the instruction cache responder.
// slave is the responder's view; master is the view of whoever drives its inputs.
interface icache_responder_if;
  logic        ask_for;
  logic [31:0] in_PC;
  logic        give_you;
  logic [31:0] give_you_ins;
  logic        flush;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_byte;
  logic        mem_done;

  modport slave (
    input  ask_for, in_PC, flush, mem_gnt, mem_byte,
    output give_you, give_you_ins, mem_req, mem_a, mem_done
  );

  modport master (
    output ask_for, in_PC, flush, mem_gnt, mem_byte,
    input  give_you, give_you_ins, mem_req, mem_a, mem_done
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped cache of 32-bit fetch windows keyed by halfword PC; misses
// read 4 bytes over the byte-wide arbiter bus, fill the entry, then respond.
module icache_responder #(
  parameter int unsigned IDX_BITS = 6
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  icache_responder_if.slave bus
);
  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = 31 - IDX_BITS;

  typedef enum logic [2:0] {StIdle, StResp, StWaitg, StRead, StFill} state_e;

  state_e              state_q, state_d;
  logic                give_you_q, give_you_d;
  logic [31:0]         ins_q, ins_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_a_q, mem_a_d;
  logic                mem_done_q, mem_done_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         req_pc_q, req_pc_d;
  logic [31:0]         line_q, line_d;
  logic                abort_q, abort_d;
  logic [Entries-1:0]  valid_q, valid_d;

  logic [TagW-1:0]     tag_mem  [Entries];
  logic [31:0]         data_mem [Entries];

  logic [IDX_BITS-1:0] req_idx, fill_idx;
  logic [TagW-1:0]     req_tag;
  logic                hit, fill_we;

  assign req_idx  = bus.in_PC[IDX_BITS:1];
  assign req_tag  = bus.in_PC[31:IDX_BITS+1];
  assign fill_idx = req_pc_q[IDX_BITS:1];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    give_you_d = 1'b0;
    ins_d      = ins_q;
    mem_req_d  = mem_req_q;
    mem_a_d    = mem_a_q;
    mem_done_d = 1'b0;
    cnt_d      = cnt_q;
    req_pc_d   = req_pc_q;
    line_d     = line_q;
    abort_d    = abort_q;
    valid_d    = valid_q;
    fill_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.ask_for && !bus.flush) begin
          if (hit) begin
            ins_d      = data_mem[req_idx];
            give_you_d = 1'b1;
            state_d    = StResp;
          end else begin
            req_pc_d  = bus.in_PC;
            mem_req_d = 1'b1;
            state_d   = StWaitg;
          end
        end
      end
      // The fetcher's PC moves at the end of this cycle, so ask_for is stale here.
      StResp: state_d = StIdle;
      StWaitg: begin
        if (bus.flush) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end else if (bus.mem_gnt) begin
          mem_a_d = req_pc_q;
          cnt_d   = 3'd0;
          abort_d = 1'b0;
          state_d = StRead;
        end
      end
      StRead: begin
        // cnt counts addresses issued; mem_byte belongs to address cnt-1.
        case (cnt_q)
          3'd1:    line_d[7:0]   = bus.mem_byte;
          3'd2:    line_d[15:8]  = bus.mem_byte;
          3'd3:    line_d[23:16] = bus.mem_byte;
          3'd4:    line_d[31:24] = bus.mem_byte;
          default: ;
        endcase
        if (cnt_q < 3'd3) mem_a_d = req_pc_q + {29'd0, cnt_q} + 32'd1;
        cnt_d = cnt_q + 3'd1;
        if (abort_q || (bus.flush && cnt_q == 3'd4)) begin
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          abort_d    = 1'b0;
          state_d    = StIdle;
        end else if (bus.flush) begin
          abort_d = 1'b1;
        end else if (cnt_q == 3'd4) begin
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        fill_we           = 1'b1;
        valid_d[fill_idx] = 1'b1;
        ins_d             = line_q;
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          give_you_d = 1'b1;
          state_d    = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      give_you_q <= 1'b0;
      ins_q      <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_done_q <= 1'b0;
      cnt_q      <= 3'd0;
      req_pc_q   <= 32'd0;
      line_q     <= 32'd0;
      abort_q    <= 1'b0;
      valid_q    <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      give_you_q <= give_you_d;
      ins_q      <= ins_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      mem_done_q <= mem_done_d;
      cnt_q      <= cnt_d;
      req_pc_q   <= req_pc_d;
      line_q     <= line_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      tag_mem[fill_idx]  <= req_pc_q[31:IDX_BITS+1];
      data_mem[fill_idx] <= line_q;
    end
  end

  assign bus.give_you     = give_you_q;
  assign bus.give_you_ins = ins_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_a        = mem_a_q;
  assign bus.mem_done     = mem_done_q;
endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: byte memory with 1-cycle read latency, scoreboard
// of expected fetch windows, vector table of hits/misses plus corner sequences.
module tb_icache_responder;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  icache_responder_if bus ();

  icache_responder #(.IDX_BITS(6)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  mem_model [256];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk_in) bus.mem_byte <= mem_model[bus.mem_a[7:0]];

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    int          gnt_delay;
  } vec_t;
  vec_t tbl [12];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model(input logic [31:0] pc);
    logic [7:0] a0, a1, a2, a3;
    a0 = pc[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    return {mem_model[a3], mem_model[a2], mem_model[a1], mem_model[a0]};
  endfunction

  always @(negedge clk_in) begin
    if (!rst_in && bus.give_you) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL give_you: got response %h expected none", bus.give_you_ins);
      end else begin
        check("give_you_ins", bus.give_you_ins, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    exp_q.delete();
  endtask

  task automatic hit_req(input logic [31:0] pc, input logic [31:0] exp_ins, input string name);
    exp_q.push_back(exp_ins);
    bus.ask_for = 1'b1;
    bus.in_PC   = pc;
    @(negedge clk_in);
    check({name, " hit give_you"}, 32'(bus.give_you), 32'd1);
    check({name, " hit mem_req"}, 32'(bus.mem_req), 32'd0);
    @(negedge clk_in);
    check({name, " held ask in resp"}, 32'(bus.give_you), 32'd0);
    bus.ask_for = 1'b0;
    @(negedge clk_in);
  endtask

  // flush_k: -1 none, 0 during WAITG, k>0 at the k-th cycle after the grant edge.
  task automatic miss_req(input logic [31:0] pc, input logic [31:0] exp_ins,
                          input int gnt_delay, input int flush_k, input string name);
    int done_k, gy_k, low_k, n_done, exp_low;
    done_k = 0; gy_k = 0; low_k = 0; n_done = 0;
    bus.ask_for = 1'b1;
    bus.in_PC   = pc;
    if (flush_k < 0) exp_q.push_back(exp_ins);
    @(negedge clk_in);
    bus.ask_for = 1'b0;
    check({name, " miss mem_req"}, 32'(bus.mem_req), 32'd1);
    check({name, " miss give_you"}, 32'(bus.give_you), 32'd0);
    if (flush_k == 0) begin
      bus.flush = 1'b1;
      @(negedge clk_in);
      bus.flush = 1'b0;
      check({name, " waitg flush mem_req"}, 32'(bus.mem_req), 32'd0);
      repeat (3) @(negedge clk_in);
      check({name, " waitg flush idle"}, 32'(bus.mem_req | bus.give_you), 32'd0);
      return;
    end
    repeat (gnt_delay) @(negedge clk_in);
    bus.mem_gnt = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      if (flush_k < 0 && k <= 4) check({name, " mem_a"}, bus.mem_a, pc + 32'(k - 1));
      if (bus.mem_done) begin
        n_done++;
        if (done_k == 0) done_k = k;
      end
      if (bus.give_you && gy_k == 0) gy_k = k;
      if (!bus.mem_req && low_k == 0) low_k = k;
      if (!bus.mem_req) bus.mem_gnt = 1'b0;
      bus.flush = (k == flush_k);
    end
    bus.flush   = 1'b0;
    bus.mem_gnt = 1'b0;
    exp_low = (flush_k > 0 && flush_k < 6) ? flush_k + 2 : 6;
    check({name, " mem_done cycle"}, 32'(done_k), 32'(exp_low));
    check({name, " mem_done pulses"}, 32'(n_done), 32'd1);
    check({name, " mem_req release"}, 32'(low_k), 32'(exp_low));
    check({name, " give_you cycle"}, 32'(gy_k), (flush_k < 0) ? 32'd7 : 32'd0);
  endtask

  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    bus.ask_for  = 1'b0;
    bus.in_PC    = 32'd0;
    bus.flush    = 1'b0;
    bus.mem_gnt  = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i * 37 + 5);
    mem_model[0] = 8'h13; mem_model[1] = 8'h05;
    mem_model[2] = 8'hf0; mem_model[3] = 8'h0f;

    tbl[0]  = '{32'h0000_0004, 1'b0, 0};
    tbl[1]  = '{32'h0000_0084, 1'b0, 1};
    tbl[2]  = '{32'h0000_0004, 1'b0, 3};
    tbl[3]  = '{32'h0000_0004, 1'b1, 0};
    tbl[4]  = '{32'h0000_0000, 1'b1, 0};
    tbl[5]  = '{32'h0000_0084, 1'b0, 2};
    tbl[6]  = '{32'h0000_0004, 1'b0, 0};
    tbl[7]  = '{32'h0000_0040, 1'b0, 1};
    tbl[8]  = '{32'h0000_0040, 1'b1, 0};
    tbl[9]  = '{32'hffff_fffe, 1'b0, 2};
    tbl[10] = '{32'hffff_fffe, 1'b1, 0};
    tbl[11] = '{32'h0000_0002, 1'b1, 0};

    repeat (2) @(negedge clk_in);
    check("reset give_you", 32'(bus.give_you), 32'd0);
    check("reset give_you_ins", bus.give_you_ins, 32'd0);
    check("reset mem_req", 32'(bus.mem_req), 32'd0);
    check("reset mem_a", bus.mem_a, 32'd0);
    check("reset mem_done", 32'(bus.mem_done), 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    miss_req(32'h0, 32'h0ff0_0513, 2, -1, "cold");
    hit_req(32'h0, 32'h0ff0_0513, "hit0");

    do_reset();
    mem_model[2] = 8'h01; mem_model[3] = 8'h45;
    mem_model[4] = 8'hb7; mem_model[5] = 8'h02;
    miss_req(32'h2, 32'h02b7_4501, 1, -1, "rvc2");
    miss_req(32'h0, 32'h4501_0513, 1, -1, "rvc0");

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].hit) hit_req(tbl[i].pc, model(tbl[i].pc), $sformatf("tbl%0d", i));
      else miss_req(tbl[i].pc, model(tbl[i].pc), tbl[i].gnt_delay, -1, $sformatf("tbl%0d", i));
    end

    miss_req(32'h10, 32'h0, 1, 3, "flush_read");
    miss_req(32'h10, model(32'h10), 0, -1, "refetch10");
    miss_req(32'h20, 32'h0, 0, 0, "flush_waitg");
    miss_req(32'h20, model(32'h20), 2, -1, "refetch20");
    miss_req(32'h30, 32'h0, 1, 6, "flush_fill");
    hit_req(32'h30, model(32'h30), "after_fill_flush");

    bus.ask_for = 1'b1; bus.flush = 1'b1; bus.in_PC = 32'h30;
    @(negedge clk_in);
    check("ask+flush give_you", 32'(bus.give_you), 32'd0);
    check("ask+flush mem_req", 32'(bus.mem_req), 32'd0);
    bus.ask_for = 1'b0; bus.flush = 1'b0;
    @(negedge clk_in);

    exp_q.push_back(model(32'h30));
    bus.ask_for = 1'b1; rdy_in = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      check("stall give_you", 32'(bus.give_you), 32'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("unstall give_you", 32'(bus.give_you), 32'd1);
    @(negedge clk_in);
    bus.ask_for = 1'b0;
    @(negedge clk_in);

    bus.ask_for = 1'b1; bus.in_PC = 32'h50;
    @(negedge clk_in);
    bus.ask_for = 1'b0;
    check("pre-reset mem_req", 32'(bus.mem_req), 32'd1);
    #3 rst_in = 1'b1;
    #1;
    check("async reset mem_req", 32'(bus.mem_req), 32'd0);
    check("async reset mem_done", 32'(bus.mem_done), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    miss_req(32'h0, model(32'h0), 1, -1, "post_reset0");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
